// File: rtl/cic_comb_if.sv
// Sample-in / result-out handshake bundle for the CIC comb stage.
interface cic_comb_if #(
  parameter int IDW = 23
);
  logic           in_valid;
  logic [IDW-1:0] data_in;
  logic [1:0]     flag_t;
  logic           out_valid;
  logic           out_ready;
  logic [IDW-1:0] data_out;

  modport master (
    output in_valid, data_in, flag_t, out_ready,
    input  out_valid, data_out
  );

  modport slave (
    input  in_valid, data_in, flag_t, out_ready,
    output out_valid, data_out
  );
endinterface

// File: rtl/cic_comb.sv
// CIC decimator comb stage: y[n] = x[n] - x[n-DM] modulo the active width, with overflow saturation.
// Define CIC_COMB_OVF_CNT_EN to build the overflow event counter behind ovf_cnt.
module cic_comb #(
  parameter int IDW = 23,
  parameter int DM  = 1,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    os_sel,
  cic_comb_if.slave     bus,
  output logic          ovf,
  output logic          overrun,
  input  logic          ovf_clr,
  output logic [CW-1:0] ovf_cnt
);

  typedef enum logic [1:0] {
    ST_BYPASS = 2'd0,
    ST_FILL   = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam logic [IDW-1:0] SAT_POS = {1'b0, {(IDW-1){1'b1}}};
  localparam logic [IDW-1:0] SAT_NEG = {1'b1, {(IDW-1){1'b0}}};

  state_t         state_r, state_s;
  logic [1:0]     fill_r, fill_s;
  logic [2:0]     os_sel_r;
  logic           flag_last_r;
  logic [IDW-1:0] delay_r [DM];
  logic           out_valid_r;
  logic [IDW-1:0] data_out_r;
  logic           ovf_r;
  logic           overrun_r;

  logic                  os_change_s, os_valid_s, toggle_s;
  logic [2:0]            sh_s;
  logic [IDW-1:0]        diff_s, ext_s, result_s;
  logic signed [IDW-1:0] tmp_s;
  logic                  produce_s, sat_s, shift_en_s, clear_s;
  logic                  drop_s, load_s, event_s;

  assign os_change_s = (os_sel != os_sel_r);
  assign os_valid_s  = (os_sel != 3'd0) && (os_sel != 3'd7);
  assign toggle_s    = (bus.flag_t[0] != flag_last_r);

  // Difference truncated to W = IDW-7+os_sel bits, then sign-extended by a shift pair.
  always_comb begin
    sh_s   = 3'd7 - os_sel;
    diff_s = bus.data_in - delay_r[DM-1];
    tmp_s  = $signed(diff_s << sh_s);
    ext_s  = tmp_s >>> sh_s;
  end

  // Next-state and per-sample datapath decisions.
  always_comb begin
    state_s    = state_r;
    fill_s     = fill_r;
    produce_s  = 1'b0;
    sat_s      = 1'b0;
    shift_en_s = 1'b0;
    clear_s    = 1'b0;
    result_s   = data_out_r;
    if (os_change_s) begin
      clear_s = 1'b1;
      if (os_valid_s) begin
        // A sample coinciding with the change becomes the first fill sample.
        shift_en_s = bus.in_valid;
        if (bus.in_valid && (fill_r == fill_r) && (DM == 1)) begin
          state_s = ST_RUN;
          fill_s  = 2'd0;
        end else begin
          state_s = ST_FILL;
          fill_s  = bus.in_valid ? 2'd1 : 2'd0;
        end
      end else begin
        state_s   = ST_BYPASS;
        fill_s    = 2'd0;
        produce_s = bus.in_valid;
        result_s  = bus.data_in;
      end
    end else begin
      case (state_r)
        ST_BYPASS: begin
          produce_s = bus.in_valid;
          result_s  = bus.data_in;
        end
        ST_FILL: begin
          shift_en_s = bus.in_valid;
          if (bus.in_valid && (fill_r == 2'(DM-1))) begin
            state_s = ST_RUN;
            fill_s  = 2'd0;
          end else if (bus.in_valid) begin
            fill_s = fill_r + 2'd1;
          end else begin
            fill_s = fill_r;
          end
        end
        ST_RUN: begin
          shift_en_s = bus.in_valid;
          produce_s  = bus.in_valid;
          sat_s      = bus.in_valid && toggle_s;
          if (toggle_s) begin
            result_s = bus.flag_t[1] ? SAT_NEG : SAT_POS;
          end else begin
            result_s = ext_s;
          end
        end
        default: begin
          state_s = ST_BYPASS;
          fill_s  = 2'd0;
        end
      endcase
    end
  end

  assign drop_s  = produce_s && out_valid_r && !bus.out_ready;
  assign load_s  = produce_s && !drop_s;
  assign event_s = sat_s && load_s;

  // State, delay line, output register and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_BYPASS;
      fill_r      <= 2'd0;
      os_sel_r    <= 3'd0;
      flag_last_r <= 1'b0;
      for (int i = 0; i < DM; i++) delay_r[i] <= {IDW{1'b0}};
      out_valid_r <= 1'b0;
      data_out_r  <= {IDW{1'b0}};
      ovf_r       <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      fill_r   <= fill_s;
      os_sel_r <= os_sel;
      if (os_change_s || bus.in_valid) flag_last_r <= bus.flag_t[0];
      if (clear_s) begin
        for (int i = 0; i < DM; i++) delay_r[i] <= {IDW{1'b0}};
        if (shift_en_s) delay_r[0] <= bus.data_in;
      end else if (shift_en_s) begin
        for (int i = 1; i < DM; i++) delay_r[i] <= delay_r[i-1];
        delay_r[0] <= bus.data_in;
      end
      if (load_s) begin
        out_valid_r <= 1'b1;
        data_out_r  <= result_s;
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (event_s)      ovf_r <= 1'b1;
      else if (ovf_clr) ovf_r <= 1'b0;
      if (drop_s)       overrun_r <= 1'b1;
      else if (ovf_clr) overrun_r <= 1'b0;
    end
  end

`ifdef CIC_COMB_OVF_CNT_EN
  logic [CW-1:0] ovf_cnt_r;

  // Saturating overflow event counter; a same-cycle event beats the clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_cnt_r <= {CW{1'b0}};
    end else if (ovf_clr) begin
      ovf_cnt_r <= event_s ? {{(CW-1){1'b0}}, 1'b1} : {CW{1'b0}};
    end else if (event_s && (ovf_cnt_r != {CW{1'b1}})) begin
      ovf_cnt_r <= ovf_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign ovf_cnt = ovf_cnt_r;
`else
  assign ovf_cnt = {CW{1'b0}};
`endif

  assign bus.out_valid = out_valid_r;
  assign bus.data_out  = data_out_r;
  assign ovf           = ovf_r;
  assign overrun       = overrun_r;

endmodule

// File: tb/tb_cic_comb.sv
// Directed self-checking bench for cic_comb (IDW=23, DM=1, CW=8).
module tb_cic_comb;

`ifdef CIC_COMB_OVF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] os_sel;
  logic       ovf, overrun, ovf_clr;
  logic [7:0] ovf_cnt;
  int checks   = 0;
  int failures = 0;

  cic_comb_if #(.IDW(23)) bus ();

  cic_comb #(.IDW(23), .DM(1), .CW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .os_sel  (os_sel),
    .bus     (bus),
    .ovf     (ovf),
    .overrun (overrun),
    .ovf_clr (ovf_clr),
    .ovf_cnt (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [22:0] d, input logic [1:0] f);
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.flag_t   = f;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    reset_n       = 1'b0;
    os_sel        = 3'd0;
    ovf_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = 23'd0;
    bus.flag_t    = 2'b00;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);

    // Plan 1: basic differences at os_sel=1
    reset_n = 1'b1;
    os_sel  = 3'd1;
    tick();
    send(23'h00010, 2'b00);
    chk("p1_fill_no_out", bus.out_valid, 0);
    send(23'h00030, 2'b00);
    chk("p1_v1", bus.out_valid, 1);
    chk("p1_d1", bus.data_out, 32'h000020);
    send(23'h00070, 2'b00);
    chk("p1_d2", bus.data_out, 32'h000040);
    tick();
    chk("p1_drain", bus.out_valid, 0);

    // Plan 2: wrap inside 17 bits and negative sign extension
    send(23'h0FFF0, 2'b00);
    chk("p2_d0", bus.data_out, 32'h00FF80);
    send(23'h10010, 2'b00);
    chk("p2_wrap", bus.data_out, 32'h000020);
    chk("p2_no_ovf", ovf, 0);
    send(23'h10000, 2'b00);
    chk("p2_neg_ext", bus.data_out, 32'h7FFFF0);

    // Plan 3: saturation at os_sel=3
    os_sel = 3'd3;
    tick();
    send(23'h00100, 2'b00);
    chk("p3_fill_no_out", bus.out_valid, 0);
    send(23'h00150, 2'b11);
    chk("p3_sat_neg", bus.data_out, 32'h400000);
    chk("p3_ovf", ovf, 1);
    chk("p3_cnt1", ovf_cnt, CNT_EN ? 1 : 0);
    send(23'h00180, 2'b11);
    chk("p3_normal", bus.data_out, 32'h000030);
    chk("p3_ovf_sticky", ovf, 1);
    send(23'h00190, 2'b00);
    chk("p3_sat_pos", bus.data_out, 32'h3FFFFF);
    chk("p3_cnt2", ovf_cnt, CNT_EN ? 2 : 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("p3_clr_ovf", ovf, 0);
    chk("p3_clr_cnt", ovf_cnt, 0);
    ovf_clr = 1'b1;
    send(23'h001A0, 2'b11);
    ovf_clr = 1'b0;
    chk("p3_set_wins_ovf", ovf, 1);
    chk("p3_set_wins_cnt", ovf_cnt, CNT_EN ? 1 : 0);

    // Plan 4: backpressure and overrun
    tick();
    bus.out_ready = 1'b0;
    send(23'h001B0, 2'b11);
    chk("p4_held_v", bus.out_valid, 1);
    chk("p4_held_d", bus.data_out, 32'h000010);
    send(23'h001F0, 2'b11);
    chk("p4_drop_d", bus.data_out, 32'h000010);
    chk("p4_overrun", overrun, 1);
    chk("p4_drop_v", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    tick();
    chk("p4_fall", bus.out_valid, 0);
    send(23'h00230, 2'b11);
    chk("p4_delay_adv", bus.data_out, 32'h000040);
    send(23'h00250, 2'b11);
    chk("p4_acc_load_v", bus.out_valid, 1);
    chk("p4_acc_load_d", bus.data_out, 32'h000020);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("p4_clr_overrun", overrun, 0);

    // Plan 5: os_sel change refills, then bypass
    os_sel = 3'd2;
    tick();
    send(23'h00010, 2'b11);
    send(23'h00020, 2'b11);
    chk("p5_run_os2", bus.data_out, 32'h000010);
    os_sel = 3'd5;
    tick();
    send(23'h01000, 2'b11);
    chk("p5_fill_no_out", bus.out_valid, 0);
    send(23'h01800, 2'b11);
    chk("p5_run_os5", bus.data_out, 32'h000800);
    os_sel = 3'd0;
    tick();
    send(23'h5ABCDE, 2'b00);
    chk("p5_bypass_v", bus.out_valid, 1);
    chk("p5_bypass_d", bus.data_out, 32'h5ABCDE);
    chk("p5_bypass_no_ovf", ovf, 0);
    tick();

    // Plan 6: mid-run reset, then counter behaviour
    os_sel = 3'd1;
    tick();
    send(23'h00000, 2'b00);
    send(23'h00005, 2'b01);
    chk("p6_pre_v", bus.out_valid, 1);
    chk("p6_pre_ovf", ovf, 1);
    reset_n = 1'b0;
    os_sel  = 3'd0;
    tick();
    reset_n = 1'b1;
    chk("p6_rst_v", bus.out_valid, 0);
    chk("p6_rst_d", bus.data_out, 0);
    chk("p6_rst_ovf", ovf, 0);
    chk("p6_rst_cnt", ovf_cnt, 0);
    send(23'h111111, 2'b00);
    chk("p6_rst_bypass", bus.data_out, 32'h111111);
    os_sel = 3'd1;
    tick();
    send(23'h00000, 2'b00);
    send(23'h00001, 2'b01);
    send(23'h00002, 2'b00);
    send(23'h00003, 2'b01);
    chk("p6_sat_d", bus.data_out, 32'h3FFFFF);
    chk("p6_cnt3", ovf_cnt, CNT_EN ? 3 : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
